// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and helpers for the fifo_rd_stream read-side streamer.
package fifo_rd_stream_pkg;

    localparam int XFER_CNT_W = 32;

    // Circular index increment that also handles non-power-of-two depths.
    function automatic int wrap_inc(input int idx, input int depth);
        return (idx == depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready stream; master = the streamer, slave = its environment.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_r_en;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_rdata,
        input  m_ready,
        output fifo_r_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rdata,
        output m_ready,
        input  fifo_r_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_rd_stream_buf.sv
// Circular prefetch buffer: write on capture at tail, read on transfer at head.
module fifo_rd_stream_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BUF_DEPTH     = 3,
    parameter int BUF_PTR_WIDTH = $clog2(BUF_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [BUF_PTR_WIDTH:0] occ,
    output logic [DATA_WIDTH-1:0] rd_data
);
    localparam int OCC_W = BUF_PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0]    mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_d [BUF_DEPTH];
    logic [BUF_PTR_WIDTH-1:0] head_q, head_d;
    logic [BUF_PTR_WIDTH-1:0] tail_q, tail_d;
    logic [OCC_W-1:0]         occ_q, occ_d;

    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (wr_en) begin
            mem_d[tail_q] = wr_data;
            tail_d        = BUF_PTR_WIDTH'(wrap_inc(int'(tail_q), BUF_DEPTH));
        end
        if (rd_en) begin
            head_d = BUF_PTR_WIDTH'(wrap_inc(int'(head_q), BUF_DEPTH));
        end
        // Simultaneous write and read leave occupancy unchanged.
        case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
            mem_q  <= mem_d;
        end
    end

    assign occ     = occ_q;
    assign rd_data = mem_q[head_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO read port into a valid/ready stream via a prefetch buffer.
// Optional macro FIFO_RD_STREAM_CNT_EN adds a 32-bit xfer_count output.
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int BUF_DEPTH     = 3,
    parameter int BUF_PTR_WIDTH = $clog2(BUF_DEPTH)
) (
    input  logic                  rclk,
    input  logic                  rrst,
`ifdef FIFO_RD_STREAM_CNT_EN
    output logic [XFER_CNT_W-1:0] xfer_count,
`endif
    fifo_rd_stream_if.master      bus
);
    localparam int               OCC_W   = BUF_PTR_WIDTH + 1;
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(BUF_DEPTH);

    logic [OCC_W-1:0]      occ;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  inflight_q, inflight_d;
    logic                  pop;
    logic                  xfer;

    // Pop decision uses registered occupancy only, so m_ready never reaches fifo_r_en.
    always_comb begin
        pop        = !rrst && !bus.fifo_empty && ((occ + OCC_W'(inflight_q)) < DEPTH_C);
        inflight_d = pop;
        xfer       = bus.m_valid && bus.m_ready;
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fifo_rd_stream_buf #(
        .DATA_WIDTH    (DATA_WIDTH),
        .BUF_DEPTH     (BUF_DEPTH),
        .BUF_PTR_WIDTH (BUF_PTR_WIDTH)
    ) u_buf (
        .clk     (rclk),
        .rst     (rrst),
        .wr_en   (inflight_q),
        .wr_data (bus.fifo_rdata),
        .rd_en   (xfer),
        .occ     (occ),
        .rd_data (head_data)
    );

    assign bus.fifo_r_en = pop;
    assign bus.m_valid   = (occ != '0);
    assign bus.m_data    = head_data;

`ifdef FIFO_RD_STREAM_CNT_EN
    logic [XFER_CNT_W-1:0] xfer_count_q, xfer_count_d;

    always_comb begin
        xfer_count_d = xfer_count_q;
        if (xfer) begin
            xfer_count_d = xfer_count_q + XFER_CNT_W'(1);
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            xfer_count_q <= '0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized bench for fifo_rd_stream against a word-count / queue reference model.
module tb_fifo_rd_stream;
    localparam int DW        = 8;
    localparam int BUF_DEPTH = 3;

    logic rclk = 1'b0;
    logic rrst;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [31:0] xfer_count;
`endif

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) bus ();

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .BUF_DEPTH  (BUF_DEPTH)
    ) dut (
        .rclk       (rclk),
        .rrst       (rrst),
`ifdef FIFO_RD_STREAM_CNT_EN
        .xfer_count (xfer_count),
`endif
        .bus        (bus)
    );

    always #5 rclk = ~rclk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: src_q is what the FIFO still holds; exp_q holds every word popped
    // but not yet transferred, oldest first. Its size equals occ + inflight.
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    bit            last_pop;
    int            exp_cnt;
    int            n_pop;
    int            n_xfer;
    int            cyc;
    int            first_xfer_cyc;
    int            last_xfer_cyc;
    logic          s_ren, s_vld;
    logic [DW-1:0] s_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit stall, input bit ready, input bit do_rst);
        bit            exp_ren;
        bit            exp_vld;
        bit            xfer;
        logic [DW-1:0] w;
        @(negedge rclk);
        rrst           = do_rst;
        bus.m_ready    = ready;
        bus.fifo_empty = stall || (src_q.size() == 0);
        #1;
        exp_ren = !do_rst && !bus.fifo_empty && (exp_q.size() < BUF_DEPTH);
        exp_vld = (int'(exp_q.size()) - int'(last_pop)) > 0;
        s_ren   = bus.fifo_r_en;
        s_vld   = bus.m_valid;
        s_data  = bus.m_data;
        chk("fifo_r_en", 32'(s_ren), 32'(exp_ren));
        chk("m_valid", 32'(s_vld), 32'(exp_vld));
        if (exp_vld && s_vld) chk("m_data", 32'(s_data), 32'(exp_q[0]));
`ifdef FIFO_RD_STREAM_CNT_EN
        chk("xfer_count", xfer_count, 32'(exp_cnt));
`endif
        xfer = exp_vld && ready;
        @(posedge rclk);
        #1;
        cyc++;
        if (do_rst) begin
            exp_q.delete();
            last_pop       = 1'b0;
            exp_cnt        = 0;
            bus.fifo_rdata = DW'($urandom);
        end else begin
            if (xfer) begin
                void'(exp_q.pop_front());
                exp_cnt++;
                n_xfer++;
                if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
                last_xfer_cyc = cyc;
            end
            if (exp_ren) begin
                w = src_q.pop_front();
                exp_q.push_back(w);
                bus.fifo_rdata = w;
                n_pop++;
            end else begin
                bus.fifo_rdata = DW'($urandom);
            end
            last_pop = exp_ren;
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        n_pop = 0;
        n_xfer = 0;
        first_xfer_cyc = -1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        bus.m_ready    = 1'b0;
        rrst           = 1'b1;
        last_pop       = 1'b0;
        exp_cnt        = 0;
        cyc            = 0;
        first_xfer_cyc = -1;
        repeat (2) @(posedge rclk);

        // Reset hold with a non-empty FIFO: no pops, outputs cleared.
        for (int i = 0; i < 6; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("rst_ren", 32'(s_ren), 32'd0);
            chk("rst_vld", 32'(s_vld), 32'd0);
            chk("rst_data", 32'(s_data), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0);
        chk("rst_release_ren", 32'(s_ren), 32'd1);

        // Latency: empty buffer, single word 0xA5.
        src_q.delete();
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        src_q.push_back(8'hA5);
        step(1'b0, 1'b0, 1'b0);
        chk("lat_ren_c0", 32'(s_ren), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("lat_vld_c1", 32'(s_vld), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_vld_c2", 32'(s_vld), 32'd1);
        chk("lat_data_c2", 32'(s_data), 32'hA5);
        step(1'b0, 1'b1, 1'b0);
        chk("lat_drained", 32'(s_vld), 32'd0);

        // Full rate: 16 sequential words, sink always ready.
        do_reset();
        for (int i = 0; i < 16; i++) src_q.push_back(DW'(i));
        for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0);
        chk("fr_count", 32'(n_xfer), 32'd16);
        chk("fr_span", 32'(last_xfer_cyc - first_xfer_cyc + 1), 32'd16);

        // Back-pressure: sink stalled for 10 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
        chk("bp_pops", 32'(n_pop), 32'd3);
        chk("bp_ren_off", 32'(s_ren), 32'd0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
        chk("bp_delivered", 32'(n_xfer), 32'd8);
        chk("bp_idle", 32'(s_vld), 32'd0);

        // FIFO drains right after a pop: in-flight word still delivered.
        do_reset();
        src_q.push_back(8'h3C);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("drain_vld", 32'(s_vld), 32'd1);
        chk("drain_data", 32'(s_data), 32'h3C);
        step(1'b1, 1'b1, 1'b0);
        chk("drain_vld_fall", 32'(s_vld), 32'd0);

        // Reset mid-burst with occ=2, inflight=1.
        do_reset();
        for (int i = 0; i < 12; i++) src_q.push_back(DW'($urandom));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("mid_rst_pre_vld", 32'(s_vld), 32'd1);
        step(1'b1, 1'b0, 1'b0);
        chk("mid_rst_vld", 32'(s_vld), 32'd0);
        chk("mid_rst_data", 32'(s_data), 32'd0);
        n_xfer = 0;
        for (int i = 0; i < 20 && n_xfer < 5; i++) step(1'b0, 1'b1, 1'b0);
        chk("mid_rst_5_xfers", 32'(n_xfer), 32'd5);
`ifdef FIFO_RD_STREAM_CNT_EN
        step(1'b1, 1'b0, 1'b0);
        chk("cnt_after_5", xfer_count, 32'd5);
`endif

        // Random traffic with stalls on both sides and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            bit st, rd, rs;
            while (src_q.size() < 4) src_q.push_back(DW'($urandom));
            st = ($urandom_range(0, 3) == 0);
            rd = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(st, rd, rs);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
